// File: rtl/count_snapshot_fifo_pkg.sv
// Shared types and constants for the counter snapshot FIFO.
package count_snap_pkg;

  localparam int DW        = 4;
  localparam int DEPTH_DEF = 4;

  typedef struct packed {
    logic [DW-1:0] epoch;
    logic [DW-1:0] cnt;
  } entry_t;

  // Occupancy needs one extra bit so that "full" (DEPTH) is representable.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int LVL_W = lvl_w(DEPTH_DEF);

endpackage

// File: rtl/count_snapshot_fifo_snap_fifo.sv
// Generic synchronous FIFO; pointers carry an extra wrap bit so that
// full and empty are told apart without a separate counter.
module snap_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign level_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (level_o == (AW+1)'(DEPTH));
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointer next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; cleared on reset so the head reads zero after a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/count_snapshot_fifo.sv
// Watches an upstream counter, counts max->0 wraps as an epoch, and on each
// trigger queues an {epoch, count} snapshot for the readout side.
module count_snapshot_fifo
  import count_snap_pkg::*;
#(
  parameter int DW    = count_snap_pkg::DW,
  parameter int DEPTH = count_snap_pkg::DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DW-1:0]             cnt_in,
  input  logic                      trig,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*DW-1:0]           out_data,
  output logic [lvl_w(DEPTH)-1:0]   level,
  output logic                      ovf,
  input  logic                      clr_ovf
);

  logic [DW-1:0]   prev_cnt_q;
  logic [DW-1:0]   epoch_q, epoch_d;
  logic            ovf_q, ovf_d;
  logic            wrap;
  logic            full, empty;
  logic            pop, drop;
  logic [2*DW-1:0] push_data;

  // A wrap is seen the cycle the counter goes from all-ones to zero,
  // regardless of whether it counted or was loaded there.
  assign wrap    = (prev_cnt_q == '1) & (cnt_in == '0);
  assign epoch_d = epoch_q + DW'(wrap);

  // The snapshot already reflects a wrap occurring in the capture cycle.
  assign push_data = {epoch_d, cnt_in};

  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  assign drop      = trig & full & ~pop;
  assign ovf       = ovf_q;

  // Sticky overflow: a drop beats a simultaneous clear.
  always_comb begin
    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  // Counter history, epoch and overflow state.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_cnt_q <= '0;
      epoch_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      prev_cnt_q <= cnt_in;
      epoch_q    <= epoch_d;
      ovf_q      <= ovf_d;
    end
  end

  snap_fifo #(
    .WIDTH (2*DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (trig),
    .pop_i   (pop),
    .wdata_i (push_data),
    .rdata_o (out_data),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

endmodule

// File: tb/tb_count_snapshot_fifo.sv
// Directed bench with a queue scoreboard for count_snapshot_fifo.
module tb_count_snapshot_fifo;
  import count_snap_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] cnt_in = 4'd0;
  logic       trig = 1'b1;
  logic       out_ready = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic [2:0] level;
  logic       ovf;

  int total = 0;
  int bad   = 0;

  logic [7:0] sb [$];
  logic [3:0] m_epoch = 4'd0;
  logic [3:0] m_prev  = 4'd0;
  logic       m_ovf   = 1'b0;

  always #5 clk = ~clk;

  count_snapshot_fifo #(.DW(4), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cnt_in    (cnt_in),
    .trig      (trig),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .ovf       (ovf),
    .clr_ovf   (clr_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("level", {29'd0, level}, sb.size());
    chk("out_valid", {31'd0, out_valid}, {31'd0, (sb.size() != 0)});
    chk("ovf", {31'd0, ovf}, {31'd0, m_ovf});
    if (sb.size() != 0) chk("out_data", {24'd0, out_data}, {24'd0, sb[0]});
  endtask

  // Advance the model with the currently driven inputs, clock, then check.
  task automatic tick();
    bit         pop, push, wrap;
    logic [3:0] en;
    entry_t     e;
    pop  = (sb.size() != 0) && out_ready;
    push = trig && ((sb.size() < 4) || pop);
    wrap = (m_prev == 4'hF) && (cnt_in == 4'h0);
    en   = wrap ? m_epoch + 4'd1 : m_epoch;
    if (rst) begin
      sb.delete();
      m_epoch = 4'd0;
      m_prev  = 4'd0;
      m_ovf   = 1'b0;
    end else begin
      if (pop) void'(sb.pop_front());
      e.epoch = en;
      e.cnt   = cnt_in;
      if (push) sb.push_back(e);
      if (clr_ovf) m_ovf = 1'b0;
      if (trig && !push) m_ovf = 1'b1;
      m_epoch = en;
      m_prev  = cnt_in;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic capture(input logic [3:0] c);
    cnt_in = c;
    trig   = 1'b1;
    tick();
    trig   = 1'b0;
  endtask

  initial begin
    // Reset with trig held high.
    tick();
    tick();
    chk("rst_data", {24'd0, out_data}, 32'h0);
    rst = 1'b0;
    trig = 1'b0;
    tick();
    chk("post_rst_level", {29'd0, level}, 32'd0);

    // Single capture.
    capture(4'd5);
    chk("single_valid", {31'd0, out_valid}, 32'd1);
    chk("single_data", {24'd0, out_data}, 32'h05);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("single_drained", {29'd0, level}, 32'd0);

    // Wrap tracking.
    cnt_in = 4'd14; tick();
    cnt_in = 4'd15; tick();
    capture(4'd0);
    chk("wrap1_data", {24'd0, out_data}, 32'h10);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    for (int i = 0; i < 14; i++) begin
      cnt_in = 4'd15; tick();
      cnt_in = 4'd0;  tick();
    end
    cnt_in = 4'd15; tick();
    capture(4'd0);
    chk("wrap16_data", {24'd0, out_data}, 32'h00);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Fill and overflow.
    for (int i = 1; i <= 4; i++) capture(4'(i));
    chk("fill_level", {29'd0, level}, 32'd4);
    capture(4'd7);
    chk("drop_ovf", {31'd0, ovf}, 32'd1);
    chk("drop_level", {29'd0, level}, 32'd4);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_order", {24'd0, out_data}, i);
      tick();
    end
    out_ready = 1'b0;
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    chk("clr_ovf", {31'd0, ovf}, 32'd0);

    // Full with simultaneous push and pop.
    for (int i = 1; i <= 4; i++) capture(4'(i));
    out_ready = 1'b1;
    capture(4'd9);
    chk("pp_ovf", {31'd0, ovf}, 32'd0);
    chk("pp_level", {29'd0, level}, 32'd4);
    chk("pp_d0", {24'd0, out_data}, 32'h02); tick();
    chk("pp_d1", {24'd0, out_data}, 32'h03); tick();
    chk("pp_d2", {24'd0, out_data}, 32'h04); tick();
    chk("pp_d3", {24'd0, out_data}, 32'h09); tick();
    out_ready = 1'b0;
    chk("pp_empty", {31'd0, out_valid}, 32'd0);

    // Backpressure and mid-operation reset, with epoch advanced to 1.
    cnt_in = 4'd15; tick();
    cnt_in = 4'd0;  tick();
    capture(4'd3);
    capture(4'd5);
    capture(4'd6);
    capture(4'd8);
    capture(4'd10);
    chk("bp_ovf", {31'd0, ovf}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold", {24'd0, out_data}, 32'h13);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("pre_rst_level", {29'd0, level}, 32'd3);
    chk("pre_rst_ovf", {31'd0, ovf}, 32'd1);
    rst = 1'b1;
    trig = 1'b1;
    tick();
    rst = 1'b0;
    trig = 1'b0;
    chk("midrst_level", {29'd0, level}, 32'd0);
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_ovf", {31'd0, ovf}, 32'd0);
    chk("midrst_data", {24'd0, out_data}, 32'h00);
    capture(4'd2);
    chk("post_rst_epoch", {24'd0, out_data}, 32'h02);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/count_snapshot_fifo.md
# count_snapshot_fifo

Downstream consumer of the 4-bit loadable up-counter. Monitors the counter value every cycle and tracks wrap-arounds (max → 0) in an epoch counter. On each trigger it captures a timestamped snapshot {epoch, count} into a small FIFO, which drains over a valid/ready interface toward the readout logic. Dropped captures are flagged by a sticky overflow bit.

## Interface

Parameters:
- DW, 4, counter width; also epoch width.
- DEPTH, 4, FIFO entries; power of two, ≥ 2.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- cnt_in  in  DW  counter value from the upstream counter's q output.
- trig  in  1  capture request, sampled each posedge.
- out_valid  out  1  FIFO head holds a valid entry.
- out_ready  in  1  consumer accepts head when out_valid & out_ready.
- out_data  out  2*DW  head entry, {epoch[DW-1:0], cnt[DW-1:0]}.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- ovf  out  1  sticky: a capture was dropped.
- clr_ovf  in  1  clears ovf.

## Operation

- Wrap detect: internal prev_cnt register holds last cycle's cnt_in. wrap = (prev_cnt == all-ones) & (cnt_in == 0). A load that produces the same max→0 transition also counts as a wrap.
- Epoch: epoch_next = epoch + wrap, modulo 2^DW (wraps silently, no saturation).
- Capture: when trig is high, the entry pushed is {epoch_next, cnt_in}, so a wrap in the capture cycle is already reflected.
- Push accepted if level < DEPTH, or if level == DEPTH and a pop occurs in the same cycle. Otherwise the capture is dropped and ovf is set.
- Pop: out_valid & out_ready removes the head. Pop with the FIFO empty cannot occur because out_valid is low.
- Push and pop in the same cycle leave level unchanged.
- ovf: set by a drop, cleared by clr_ovf. If a drop and clr_ovf occur in the same cycle, set wins.
- FIFO order is strict; no reordering and no bypass.

## Timing

- Reset values: out_valid=0, out_data=0, level=0, ovf=0; internal epoch=0, prev_cnt=0, pointers=0.
  - With prev_cnt=0 after reset, cnt_in=0 in the first post-reset cycle is not a wrap.
- Latency: trig at edge n with the FIFO empty gives out_valid=1 and the entry on out_data after edge n, visible in cycle n+1. Zero-cycle bypass is not allowed.
- out_data and out_valid are registered or derived directly from FIFO storage and pointers. They do not depend combinationally on out_ready, trig or cnt_in.
- Backpressure: while out_valid & !out_ready, out_data must hold stable.
- level updates on the same edge as the push or pop.
- rst in mid-operation flushes all entries and clears epoch, prev_cnt and ovf on that edge. trig in the reset cycle is ignored.

## Structure

- Package count_snap_pkg:
  - DW default constant.
  - Entry typedef: packed struct {epoch, cnt}.
  - Helper localparam for the level width.
- Sub-module snap_fifo: generic synchronous FIFO.
  - Parameters: width, depth.
  - Ports: push/pop/full/empty/level.
  - Occupancy uses an extra pointer wrap bit.
- The top level holds only prev_cnt, epoch, the wrap detect, the ovf logic and the snap_fifo instance.

## Test plan

- Reset: assert rst with trig=1 for 2 cycles, then release.
  - Required: all outputs 0; level stays 0; no entry appears.
- Single capture: cnt_in=5, trig pulse at edge n.
  - Required: out_valid=1 in cycle n+1, out_data=0x05.
  - out_ready=1 then gives level 0 and out_valid=0.
- Wrap tracking: drive cnt_in 14, 15, 0 with trig in the cnt=0 cycle.
  - Required: entry 0x10.
  - Repeat 16 wraps: the epoch field returns to 0.
- Fill/overflow, out_ready=0:
  - 4 captures of cnt 1–4 give level=4.
  - 5th trig with cnt=7: dropped, ovf=1.
  - Drain order: 0x01, 0x02, 0x03, 0x04.
  - clr_ovf gives ovf=0.
- Full with simultaneous push/pop: level=4 and trig with cnt=9 while out_ready=1.
  - Required: no drop, ovf=0, level stays 4.
  - 0x09 is popped last, after the remaining three entries.
- Backpressure and mid-op reset:
  - Hold out_ready=0 for 5 cycles: out_data stays stable.
  - Assert rst with level=3 and ovf=1: the next cycle has level=0, out_valid=0, ovf=0.
  - A capture after reset shows epoch=0.
